// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
// Holds the controller FSM state encoding, the register-address type and the
// default memory-wait watchdog limit, plus the load-use detection helper.
package hazard_ctrl_pkg;

   // Architectural register index (x0..x31)
   typedef logic [4:0] reg_addr_t;

   // Controller FSM encoding; CTRL_ILLEGAL is never entered on purpose and
   // falls back to RUN on the next clock.
   typedef enum logic [1:0] {
      RUN          = 2'd0,
      IMEM_WAIT    = 2'd1,
      DMEM_WAIT    = 2'd2,
      CTRL_ILLEGAL = 2'd3
   } ctrl_state_t;

   // Default number of consecutive wait cycles tolerated before the
   // watchdog flags a stuck memory.
   localparam int HAZ_TIMEOUT_DEFAULT = 64;

   // A load in EX whose destination is read by the instruction in ID.
   // Writes to x0 never create a dependency, and rs2 only matters when the
   // ID instruction actually reads it.
   function automatic logic load_use(
      input logic      ex_mem_read,
      input reg_addr_t ex_rd,
      input reg_addr_t id_rs1,
      input reg_addr_t id_rs2,
      input logic      id_uses_rs2
   );
      logic rs1_hit;
      logic rs2_hit;
      rs1_hit  = (ex_rd == id_rs1);
      rs2_hit  = id_uses_rs2 && (ex_rd == id_rs2);
      load_use = ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
   endfunction

endpackage

// File: rtl/hazard_wait_wdog.sv
// Memory-wait watchdog for the hazard controller.
// Counts consecutive cycles spent in a single wait state, saturating at
// TIMEOUT, and raises a sticky mem_timeout flag once that limit is reached.
// The flag is only cleared by reset.
module hazard_wait_wdog
   import hazard_ctrl_pkg::*;
#(
   parameter int TIMEOUT = HAZ_TIMEOUT_DEFAULT,
   parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic in_wait,
   input  logic state_change,
   output logic mem_timeout
);

   localparam logic [TO_W-1:0] CNT_MAX = TO_W'(TIMEOUT);

   logic [TO_W-1:0] wait_cnt;
   logic [TO_W-1:0] wait_cnt_next;

   // Next count: restart whenever we leave the wait or switch wait kind,
   // otherwise count up and hold at the limit.
   always_comb begin
      wait_cnt_next = '0;
      if (!in_wait || state_change) begin
         wait_cnt_next = '0;
      end else if (wait_cnt == CNT_MAX) begin
         wait_cnt_next = CNT_MAX;
      end else begin
         wait_cnt_next = wait_cnt + TO_W'(1);
      end
   end

   // Counter register and sticky timeout flag; the flag rises in the same
   // clock that the counter reaches the limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         wait_cnt <= wait_cnt_next;
         if (wait_cnt_next == CNT_MAX) begin
            mem_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Central sequencing controller for the 5-stage RV32I pipeline.
// Produces hold/flush enables for the PC and the IF/ID, ID/EX, EX/MEM and
// MEM/WB registers, covering load-use stalls, EX-resolved redirects and
// multi-cycle instruction/data memory waits (with a watchdog).
// Outputs are combinational from the current state and inputs so a hazard
// acts in the cycle it is seen.
// Optional build macro: HAZARD_PERF_CNT_EN adds perf_stall_cyc and
// perf_flush_cnt performance counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int TIMEOUT = HAZ_TIMEOUT_DEFAULT,
   parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        ex_pc_src,
   input  logic        imem_ready,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   output logic        pc_stall,
   output logic        if_id_stall,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        ex_mem_stall,
   output logic        mem_wb_bubble,
   output logic [1:0]  ctrl_state,
   output logic        mem_timeout
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cyc,
   output logic [31:0] perf_flush_cnt
`endif
);

   ctrl_state_t state;
   ctrl_state_t state_next;

   logic lu;
   logic dmem_wait;
   logic in_wait;
   logic state_change;
   logic timeout_q;

   // Hazard conditions seen this cycle. A data-memory wait is either an
   // ongoing DMEM_WAIT not yet completed, or a fresh unfinished access
   // raised from RUN or IMEM_WAIT.
   always_comb begin
      lu        = load_use(ex_mem_read, ex_rd, id_rs1, id_rs2, id_uses_rs2);
      dmem_wait = 1'b0;
      case (state)
         DMEM_WAIT:      dmem_wait = !dmem_ready;
         RUN, IMEM_WAIT: dmem_wait = dmem_req && !dmem_ready;
         default:        dmem_wait = 1'b0;
      endcase
   end

   // Next-state logic. Data waits outrank everything; a redirect keeps RUN
   // (the new fetch starts next cycle); an instruction wait is entered only
   // when nothing higher applies. The unused encoding recovers to RUN.
   always_comb begin
      state_next = state;
      case (state)
         RUN: begin
            if (dmem_wait) begin
               state_next = DMEM_WAIT;
            end else if (ex_pc_src) begin
               state_next = RUN;
            end else if (!imem_ready) begin
               state_next = IMEM_WAIT;
            end else begin
               state_next = RUN;
            end
         end
         IMEM_WAIT: begin
            if (dmem_wait) begin
               state_next = DMEM_WAIT;
            end else if (imem_ready) begin
               state_next = RUN;
            end else begin
               state_next = IMEM_WAIT;
            end
         end
         DMEM_WAIT: begin
            if (dmem_ready) begin
               state_next = RUN;
            end else begin
               state_next = DMEM_WAIT;
            end
         end
         default: state_next = RUN;
      endcase
   end

   // State register; reset drops any outstanding wait at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Pipeline enables by priority: reset, data wait, redirect, fetch wait,
   // load-use. Reset loads bubbles into IF/ID and ID/EX and holds nothing.
   always_comb begin
      pc_stall      = 1'b0;
      if_id_stall   = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_stall  = 1'b0;
      mem_wb_bubble = 1'b0;
      if (rst) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (dmem_wait) begin
         pc_stall      = 1'b1;
         if_id_stall   = 1'b1;
         ex_mem_stall  = 1'b1;
         mem_wb_bubble = 1'b1;
      end else if (ex_pc_src) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (!imem_ready) begin
         pc_stall    = 1'b1;
         if_id_flush = 1'b1;
      end else if (lu) begin
         pc_stall    = 1'b1;
         if_id_stall = 1'b1;
         id_ex_flush = 1'b1;
      end
   end

   // Watchdog hook-up: count while in a wait state, restart on any change.
   always_comb begin
      in_wait      = (state == IMEM_WAIT) || (state == DMEM_WAIT);
      state_change = (state_next != state);
   end

   hazard_wait_wdog #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_wdog (
      .clk          (clk),
      .rst          (rst),
      .in_wait      (in_wait),
      .state_change (state_change),
      .mem_timeout  (timeout_q)
   );

   // Status outputs read as idle while reset is asserted.
   always_comb begin
      ctrl_state  = rst ? 2'd0 : state;
      mem_timeout = rst ? 1'b0 : timeout_q;
   end

`ifdef HAZARD_PERF_CNT_EN
   // Free-running performance counters: PC-hold cycles and redirects.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cyc <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (pc_stall) begin
            perf_stall_cyc <= perf_stall_cyc + 32'd1;
         end
         if (ex_pc_src) begin
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline sequencing controller for the 5-stage RV32I pipeline. It produces the hold/flush enables for the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It handles three cases: load-use hazards, taken branch/jump redirects resolved in EX, and multi-cycle instruction/data memory waits, which it tracks with a wait-state FSM and a watchdog.

Parameters:
TIMEOUT, 64, maximum consecutive wait cycles in a memory-wait state before mem_timeout is raised.
TO_W, $clog2(TIMEOUT+1), width of the wait counter.

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous, active-high reset
id_rs1  in  5  rs1 of instruction in ID (reg_addr_t)
id_rs2  in  5  rs2 of instruction in ID (reg_addr_t)
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  rd of instruction in EX (reg_addr_t)
ex_mem_read  in  1  EX instruction is a load
ex_pc_src  in  1  EX resolved taken branch/jump (redirect)
imem_ready  in  1  fetch data valid this cycle
dmem_req  in  1  MEM-stage instruction accesses data memory
dmem_ready  in  1  data memory access completes this cycle
pc_stall  out  1  hold PC register
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  load NOP into IF/ID
id_ex_flush  out  1  load bubble into ID/EX
ex_mem_stall  out  1  hold ID/EX and EX/MEM
mem_wb_bubble  out  1  write bubble into MEM/WB
ctrl_state  out  2  ctrl_state_t, current FSM state
mem_timeout  out  1  sticky watchdog error

Behaviour:
- FSM states (ctrl_state_t): RUN=0, IMEM_WAIT=1, DMEM_WAIT=2. Unused encoding 3 returns to RUN next cycle.
- Reset: while rst=1 and the cycle after, state=RUN, wait counter=0, mem_timeout=0. During rst=1 the outputs are: if_id_flush=1, id_ex_flush=1, all other outputs 0. A mid-access reset abandons the wait immediately.
- Outputs are Mealy (combinational from state and inputs), so hazards act in the same cycle they are detected. Registered state updates on posedge clk.
- Load-use: lu = ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
- Priority per cycle, highest first:
  1. dmem wait (state DMEM_WAIT, or RUN with dmem_req & !dmem_ready): pc_stall=if_id_stall=ex_mem_stall=mem_wb_bubble=1, no flushes. Branch redirect is frozen because EX is held.
  2. ex_pc_src=1: if_id_flush=1, id_ex_flush=1, pc_stall=0. PC takes the target; lu is ignored.
  3. !imem_ready: pc_stall=1, if_id_flush=1 (no stale fetch enters ID). ID onward advances.
  4. lu=1: pc_stall=1, if_id_stall=1, id_ex_flush=1.
  5. Otherwise all outputs 0.
- Transitions:
  - RUN -> DMEM_WAIT on dmem_req & !dmem_ready.
  - RUN -> IMEM_WAIT on !imem_ready with no higher-priority event.
  - IMEM_WAIT -> RUN on imem_ready. ex_pc_src during IMEM_WAIT flushes per rule 2 and stays in IMEM_WAIT.
  - DMEM_WAIT -> RUN on dmem_ready. In that exit cycle ex_mem_stall=0 and mem_wb_bubble=0.
  - A dmem_req stall has priority over imem: IMEM_WAIT -> DMEM_WAIT when dmem_req & !dmem_ready.
- Watchdog:
  - Counter increments each cycle in IMEM_WAIT/DMEM_WAIT, clears on RUN and on every state change, and saturates at TIMEOUT.
  - mem_timeout sets when the counter reaches TIMEOUT and holds until rst.
  - Stall behaviour is unaffected by the timeout.

Optional Feature:
HAZARD_PERF_CNT_EN. When defined, adds outputs perf_stall_cyc (32) and perf_flush_cnt (32):
- perf_stall_cyc increments on every cycle with pc_stall=1.
- perf_flush_cnt increments on each ex_pc_src redirect.
- Both wrap at 2^32 and clear on rst.
When undefined, the ports are absent and no counter logic exists.

Decomposition:
- RISCV_pkg additions: ctrl_state_t enum (2-bit), reg_addr_t (logic [4:0]) if not already present, and HAZ_TIMEOUT_DEFAULT=64.
- One sub-module: hazard_wait_wdog, holding the wait counter, saturation logic and sticky mem_timeout. Its inputs are clk, rst, in_wait and state_change.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 -> one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1. Next cycle (ex_mem_read=0) all outputs 0.
- x0 guard: ex_mem_read=1, ex_rd=0, id_rs1=0 -> no stall.
- Branch beats load-use: ex_pc_src=1 with lu true -> if_id_flush=1, id_ex_flush=1, pc_stall=0.
- Dmem wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> ctrl_state=2 for 3 cycles with ex_mem_stall=1 and mem_wb_bubble=1. Exit cycle has ex_mem_stall=0, then ctrl_state=0.
- Watchdog: TIMEOUT=4, imem_ready=0 held for 6 cycles -> mem_timeout rises after 4 wait cycles and stays 1 after imem_ready=1 until rst.
- Mid-wait reset: rst=1 during DMEM_WAIT -> next cycle ctrl_state=0, counter 0, if_id_flush=1 and id_ex_flush=1 while rst is high.
